mrr_pathway_mux: RTL and testbench
==================================

Name: mrr_pathway_mux

Overview:
- Downstream stage of the MRR header/decoder core.
- Collects the per-pathway 32-bit AXI-Stream packet outputs (tdata/tkeep/tlast/tvalid) of all decode pathways.
- Merges them packet-atomically, in round-robin order, into a single host-bound stream.
- Prefixes each packet with a header word naming the source pathway; aborts stalled packets on timeout.

Parameters:
- NUM_DECODE_PATHWAYS, 4, number of input pathways (1..16)
- DATA_WIDTH, 32, stream word width
- TIMEOUT_WIDTH, 16, width of the stall-timeout counter

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- i_tdata  in  DATA_WIDTH*NUM_DECODE_PATHWAYS  pathway p occupies bits [32*(p+1)-1 -: 32]
- i_tkeep  in  NUM_DECODE_PATHWAYS  per-pathway beat keep flag
- i_tlast  in  NUM_DECODE_PATHWAYS  per-pathway end of packet
- i_tvalid  in  NUM_DECODE_PATHWAYS  per-pathway valid
- i_tready  out  NUM_DECODE_PATHWAYS  per-pathway ready
- o_tdata  out  DATA_WIDTH  merged stream data
- o_tlast  out  1  merged end of packet
- o_tvalid  out  1  merged valid
- o_tready  in  1  merged ready
- timeout_len  in  TIMEOUT_WIDTH  stall cycles before abort; 0 disables the timeout
- o_active_pathway  out  4  currently granted pathway index
- abort_count  out  16  number of aborted packets, saturating

Behaviour:
- Reset values:
  - o_tvalid=0, o_tdata=0, o_tlast=0, i_tready=0
  - o_active_pathway=0, abort_count=0, seq=0
  - rr_ptr=NUM_DECODE_PATHWAYS-1, flushing=0, state=IDLE
- Output register: single stage. It is "free" when !o_tvalid | o_tready. A word loaded into it appears on o_tdata the next cycle (1-cycle latency). o_tvalid holds until accepted; o_tdata/o_tlast are stable while o_tvalid & !o_tready.
- Eligibility: pathway p is eligible when i_tvalid[p] & !flushing[p].
- IDLE:
  - Grant the first eligible pathway searching from rr_ptr+1, wrapping modulo NUM_DECODE_PATHWAYS.
  - Set o_active_pathway and rr_ptr to the grant; go to HDR.
  - No eligible pathway: stay in IDLE; i_tready=0 except for flushing pathways.
- HDR:
  - When the output register is free, load {8'hC0, 4'h0, idx[3:0], seq[15:0]} with tlast=0.
  - seq increments by 1 (wraps 16'hFFFF→0). Go to STREAM.
- STREAM:
  - i_tready[g] = output register free. All other non-flushing pathways get i_tready=0.
  - Accepted beat with i_tkeep=1: load into the output register, o_tlast=i_tlast[g].
  - Accepted beat with i_tkeep=0 and i_tlast=0: consumed and discarded; nothing loaded.
  - Beat with i_tlast=1: always forwarded regardless of tkeep, so every packet terminates.
  - After the tlast beat is accepted, go to IDLE. Arbitration resumes the following cycle; no same-cycle re-grant.
- Timeout (STREAM only):
  - Counter clears on HDR exit and on every accepted input beat.
  - Otherwise it increments each cycle the output register is free and i_tvalid[g]=0; it does not count while output backpressure blocks.
  - When counter==timeout_len (timeout_len≠0) and no beat is accepted that cycle:
    - load terminator {16'hDEAD, 12'h0, idx[3:0]} with tlast=1;
    - set flushing[g]; increment abort_count (saturate at 16'hFFFF); go to IDLE.
  - If a beat is accepted in the same cycle the count is reached, the beat wins and there is no abort.
- Flush:
  - While flushing[p]: i_tready[p]=1 unconditionally; beats are discarded.
  - flushing[p] clears on the accepted tlast beat; the pathway becomes eligible again the next cycle.
- Reset mid-packet: all state drops immediately. There is no partial-packet completion; downstream must tolerate a truncated frame.

Test Plan:
- Pathways 0 and 2 each present 3-word packets (0x11,0x12,0x13 / 0x21,0x22,0x23) simultaneously, o_tready=1 → output C000_0000,11,12,13(last),C002_0001,21,22,23(last); p2's first ready only after p0's tlast.
- Pathway 1 sends 4 beats with tkeep=1,0,1,0 (tlast on 4th) → header plus beats 1, 3, 4 forwarded; o_tlast on beat 4.
- o_tready toggles 1/0 every cycle during a 5-word packet → no loss or duplication; o_tdata stable while stalled; timeout counter does not advance.
- timeout_len=8; pathway 3 sends 2 beats then idles 8 cycles, later sends 2 beats with tlast → DEAD_0003 with o_tlast; abort_count=1; late beats consumed and never output.
- All 4 pathways continuously valid for 8 packets → grant order 0,1,2,3,0,1,2,3; seq 0..7 in headers.
- rst asserted mid-STREAM → next cycle o_tvalid=0, i_tready=0, abort_count=0; first post-reset header carries seq=0 and comes from pathway 0.

Source files
------------

// File: rtl/mrr_pathway_mux.sv
// mrr_pathway_mux
// Merges the per-pathway packet streams of the MRR decoder into one host-bound
// stream. Whole packets are granted round-robin, each one is prefixed with a
// header word naming its source pathway, and a packet whose source stalls for
// too long is closed with a terminator word while the rest of it is drained.

module mrr_pathway_mux #(
    parameter int NUM_DECODE_PATHWAYS = 4,
    parameter int DATA_WIDTH          = 32,
    parameter int TIMEOUT_WIDTH       = 16
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [DATA_WIDTH*NUM_DECODE_PATHWAYS-1:0]   i_tdata,
    input  logic [NUM_DECODE_PATHWAYS-1:0]              i_tkeep,
    input  logic [NUM_DECODE_PATHWAYS-1:0]              i_tlast,
    input  logic [NUM_DECODE_PATHWAYS-1:0]              i_tvalid,
    output logic [NUM_DECODE_PATHWAYS-1:0]              i_tready,
    output logic [DATA_WIDTH-1:0]                       o_tdata,
    output logic                                        o_tlast,
    output logic                                        o_tvalid,
    input  logic                                        o_tready,
    input  logic [TIMEOUT_WIDTH-1:0]                    timeout_len,
    output logic [3:0]                                  o_active_pathway,
    output logic [15:0]                                 abort_count
);

    localparam int NP = NUM_DECODE_PATHWAYS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_STREAM
    } state_t;

    state_t                     r_state;
    state_t                     w_nextState;

    logic                       r_outValid;
    logic [DATA_WIDTH-1:0]      r_outData;
    logic                       r_outLast;
    logic [3:0]                 r_active;
    logic [3:0]                 r_rrPtr;
    logic [15:0]                r_seq;
    logic [NP-1:0]              r_flushing;
    logic [TIMEOUT_WIDTH-1:0]   r_timer;
    logic [15:0]                r_abortCount;

    logic                       w_outFree;
    logic [NP-1:0]              w_eligible;
    logic [2*NP-1:0]            w_eligDouble;
    logic [NP-1:0]              w_rot;
    logic                       w_grantFound;
    logic [4:0]                 w_grantOffset;
    logic [4:0]                 w_grantSum;
    logic [3:0]                 w_grantIdx;

    logic [NP-1:0]              w_gMask;
    logic                       w_gValid;
    logic                       w_gKeep;
    logic                       w_gLast;
    logic [DATA_WIDTH-1:0]      w_gData;

    logic                       w_accept;
    logic                       w_timeoutHit;
    logic                       w_load;
    logic [DATA_WIDTH-1:0]      w_loadData;
    logic                       w_loadLast;
    logic                       w_grantTake;
    logic                       w_hdrTake;

    // The output register can take a new word when empty or being drained this cycle.
    assign w_outFree    = !r_outValid | o_tready;
    assign w_eligible   = i_tvalid & ~r_flushing;
    assign w_eligDouble = {w_eligible, w_eligible};

    // Per-pathway signals of the currently granted pathway, picked out by a one-hot mask.
    assign w_gMask  = NP'(1) << r_active;
    assign w_gValid = |(i_tvalid & w_gMask);
    assign w_gKeep  = |(i_tkeep & w_gMask);
    assign w_gLast  = |(i_tlast & w_gMask);

    // Select the data word of the granted pathway.
    always_comb begin
        w_gData = '0;
        for (int p = 0; p < NP; p++) begin
            if (r_active == 4'(p)) begin
                w_gData = i_tdata[DATA_WIDTH*p +: DATA_WIDTH];
            end
        end
    end

    // Round-robin search: rotate eligibility so bit 0 is the pathway after rr_ptr, take the first set bit.
    always_comb begin
        w_rot         = NP'(w_eligDouble >> ({1'b0, r_rrPtr} + 5'd1));
        w_grantFound  = 1'b0;
        w_grantOffset = '0;
        for (int i = 0; i < NP; i++) begin
            if (!w_grantFound && w_rot[i]) begin
                w_grantFound  = 1'b1;
                w_grantOffset = 5'(i);
            end
        end
        w_grantSum = {1'b0, r_rrPtr} + 5'd1 + w_grantOffset;
        if (w_grantSum >= 5'(NP)) begin
            w_grantSum = w_grantSum - 5'(NP);
        end
        w_grantIdx = w_grantSum[3:0];
    end

    // A beat is taken from the granted pathway only while streaming and the output can hold it.
    assign w_accept     = (r_state == ST_STREAM) & w_gValid & w_outFree;
    assign w_timeoutHit = (r_state == ST_STREAM) & (timeout_len != '0) &
                          (r_timer == timeout_len) & !w_accept & w_outFree;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state, per-pathway ready and output-register load decisions.
    always_comb begin
        w_nextState = r_state;
        w_load      = 1'b0;
        w_loadData  = '0;
        w_loadLast  = 1'b0;
        w_grantTake = 1'b0;
        w_hdrTake   = 1'b0;
        i_tready    = r_flushing;
        case (r_state)
            ST_IDLE: begin
                if (w_grantFound) begin
                    w_grantTake = 1'b1;
                    w_nextState = ST_HDR;
                end
            end
            ST_HDR: begin
                if (w_outFree) begin
                    w_load      = 1'b1;
                    w_loadData  = DATA_WIDTH'({8'hC0, 4'h0, r_active, r_seq});
                    w_loadLast  = 1'b0;
                    w_hdrTake   = 1'b1;
                    w_nextState = ST_STREAM;
                end
            end
            ST_STREAM: begin
                i_tready = r_flushing | (w_gMask & {NP{w_outFree}});
                if (w_accept) begin
                    if (w_gKeep || w_gLast) begin
                        w_load     = 1'b1;
                        w_loadData = w_gData;
                        w_loadLast = w_gLast;
                    end
                    if (w_gLast) begin
                        w_nextState = ST_IDLE;
                    end
                end else if (w_timeoutHit) begin
                    w_load      = 1'b1;
                    w_loadData  = DATA_WIDTH'({16'hDEAD, 12'h000, r_active});
                    w_loadLast  = 1'b1;
                    w_nextState = ST_IDLE;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Output register, grant bookkeeping, sequence number, stall timer, flush flags and abort counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outValid   <= 1'b0;
            r_outData    <= '0;
            r_outLast    <= 1'b0;
            r_active     <= '0;
            r_rrPtr      <= 4'(NP - 1);
            r_seq        <= '0;
            r_flushing   <= '0;
            r_timer      <= '0;
            r_abortCount <= '0;
        end else begin
            if (w_outFree) begin
                r_outValid <= w_load;
                if (w_load) begin
                    r_outData <= w_loadData;
                    r_outLast <= w_loadLast;
                end
            end
            if (w_grantTake) begin
                r_active <= w_grantIdx;
                r_rrPtr  <= w_grantIdx;
            end
            if (w_hdrTake) begin
                r_seq <= r_seq + 16'd1;
            end
            if (w_hdrTake || w_accept) begin
                r_timer <= '0;
            end else if ((r_state == ST_STREAM) && w_outFree && !w_gValid) begin
                r_timer <= r_timer + 1'b1;
            end
            r_flushing <= (r_flushing & ~(i_tvalid & i_tlast)) |
                          (w_timeoutHit ? w_gMask : '0);
            if (w_timeoutHit && (r_abortCount != 16'hFFFF)) begin
                r_abortCount <= r_abortCount + 16'd1;
            end
        end
    end

    assign o_tvalid         = r_outValid;
    assign o_tdata          = r_outData;
    assign o_tlast          = r_outLast;
    assign o_active_pathway = r_active;
    assign abort_count      = r_abortCount;

endmodule

// File: tb/tb_mrr_pathway_mux.sv
// tb_mrr_pathway_mux
// Drives packets on the decode pathways from per-pathway beat queues and checks
// the merged stream against a queue of expected words built as stimulus is queued.

module tb_mrr_pathway_mux;

    localparam int NP = 4;
    localparam int DW = 32;
    localparam int TW = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [DW*NP-1:0]  i_tdata;
    logic [NP-1:0]     i_tkeep;
    logic [NP-1:0]     i_tlast;
    logic [NP-1:0]     i_tvalid;
    logic [NP-1:0]     i_tready;
    logic [DW-1:0]     o_tdata;
    logic              o_tlast;
    logic              o_tvalid;
    logic              o_tready;
    logic [TW-1:0]     timeout_len;
    logic [3:0]        o_active_pathway;
    logic [15:0]       abort_count;

    typedef struct {
        logic [31:0] data;
        logic        keep;
        logic        last;
        int          delay;
    } beat_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        isHdr;
        logic [3:0]  idx;
    } exp_t;

    beat_t       beatQ[NP][$];
    exp_t        expQ[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] expSeq = 16'd0;
    logic [NP-1:0] hs;
    bit          loaded[NP];
    int          waitCnt[NP];
    bit          watchP2 = 0;
    bit          p0Done = 0;
    bit          checkedP2 = 0;

    mrr_pathway_mux #(
        .NUM_DECODE_PATHWAYS(NP),
        .DATA_WIDTH(DW),
        .TIMEOUT_WIDTH(TW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_tdata(i_tdata),
        .i_tkeep(i_tkeep),
        .i_tlast(i_tlast),
        .i_tvalid(i_tvalid),
        .i_tready(i_tready),
        .o_tdata(o_tdata),
        .o_tlast(o_tlast),
        .o_tvalid(o_tvalid),
        .o_tready(o_tready),
        .timeout_len(timeout_len),
        .o_active_pathway(o_active_pathway),
        .abort_count(abort_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic pushBeat(input int p, input logic [31:0] data, input logic keep, input logic last, input int delay);
        beatQ[p].push_back('{data, keep, last, delay});
    endtask

    task automatic expectHeader(input int p);
        expQ.push_back('{{8'hC0, 4'h0, 4'(p), expSeq}, 1'b0, 1'b1, 4'(p)});
        expSeq = expSeq + 16'd1;
    endtask

    task automatic expectWord(input logic [31:0] data, input logic last);
        expQ.push_back('{data, last, 1'b0, 4'h0});
    endtask

    // Queues a plain packet of len words base, base+1, ... and the words it should produce.
    task automatic applyStimulus(input int p, input logic [31:0] base, input int len, input int delay);
        expectHeader(p);
        for (int i = 0; i < len; i++) begin
            pushBeat(p, base + 32'(i), 1'b1, (i == len - 1), (i == 0) ? 0 : delay);
            expectWord(base + 32'(i), (i == len - 1));
        end
    endtask

    function automatic int pendingBeats();
        int n = 0;
        for (int p = 0; p < NP; p++) n += beatQ[p].size();
        return n;
    endfunction

    task automatic waitDrain(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (expQ.size() == 0 && pendingBeats() == 0) break;
        end
        repeat (2) @(negedge clk);
        checkOutput({tag, " drain"}, 64'(expQ.size() + pendingBeats()), 64'd0);
    endtask

    // Pathway driver: presents the head beat of each queue, honouring its idle delay, pops it on handshake.
    initial begin
        i_tvalid = '0;
        i_tkeep  = '0;
        i_tlast  = '0;
        i_tdata  = '0;
        hs       = '0;
        for (int p = 0; p < NP; p++) begin
            loaded[p]  = 0;
            waitCnt[p] = 0;
        end
        forever begin
            @(negedge clk);
            hs = i_tvalid & i_tready;
            if (watchP2) begin
                if (i_tready[2] && !checkedP2) begin
                    checkOutput("p2 ready only after p0 last", 64'(p0Done), 64'd1);
                    checkedP2 = 1;
                end
                if (hs[0] && i_tlast[0]) p0Done = 1;
            end
            @(posedge clk);
            #1;
            for (int p = 0; p < NP; p++) begin
                if (rst) begin
                    loaded[p]   = 0;
                    i_tvalid[p] = 1'b0;
                end else begin
                    if (hs[p] && loaded[p] && beatQ[p].size() > 0) begin
                        void'(beatQ[p].pop_front());
                        loaded[p] = 0;
                    end
                    if (!loaded[p] && beatQ[p].size() > 0) begin
                        loaded[p]  = 1;
                        waitCnt[p] = beatQ[p][0].delay;
                    end
                    if (loaded[p] && waitCnt[p] == 0) begin
                        i_tvalid[p]           = 1'b1;
                        i_tdata[DW*p +: DW]   = beatQ[p][0].data;
                        i_tkeep[p]            = beatQ[p][0].keep;
                        i_tlast[p]            = beatQ[p][0].last;
                    end else begin
                        i_tvalid[p] = 1'b0;
                        if (loaded[p]) waitCnt[p]--;
                    end
                end
            end
        end
    end

    // Output monitor: compares every presented word with the scoreboard head, pops on handshake.
    always @(negedge clk) begin
        if (!rst && o_tvalid) begin
            if (expQ.size() == 0) begin
                if (o_tready) checkOutput("unexpected output valid", 64'(o_tvalid), 64'd0);
            end else begin
                checkOutput("tdata", 64'(o_tdata), 64'(expQ[0].data));
                checkOutput("tlast", 64'(o_tlast), 64'(expQ[0].last));
                if (o_tready) begin
                    if (expQ[0].isHdr) checkOutput("active pathway", 64'(o_active_pathway), 64'(expQ[0].idx));
                    void'(expQ.pop_front());
                end
            end
        end
    end

    // Main sequence of directed scenarios.
    initial begin
        rst         = 1'b1;
        o_tready    = 1'b0;
        timeout_len = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset o_tvalid", 64'(o_tvalid), 64'd0);
        checkOutput("reset o_tdata", 64'(o_tdata), 64'd0);
        checkOutput("reset o_tlast", 64'(o_tlast), 64'd0);
        checkOutput("reset i_tready", 64'(i_tready), 64'd0);
        checkOutput("reset active", 64'(o_active_pathway), 64'd0);
        checkOutput("reset abort_count", 64'(abort_count), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Two simultaneous packets: pathway 0 first, pathway 2 held off until p0 ends.
        o_tready = 1'b1;
        watchP2  = 1;
        applyStimulus(0, 32'h11, 3, 0);
        applyStimulus(2, 32'h21, 3, 0);
        waitDrain("two packets", 200);
        watchP2 = 0;
        checkOutput("p2 was granted", 64'(checkedP2), 64'd1);

        // tkeep pattern 1,0,1,0 with tlast on the fourth beat.
        expectHeader(1);
        pushBeat(1, 32'h31, 1'b1, 1'b0, 0);
        expectWord(32'h31, 1'b0);
        pushBeat(1, 32'h32, 1'b0, 1'b0, 0);
        pushBeat(1, 32'h33, 1'b1, 1'b0, 0);
        expectWord(32'h33, 1'b0);
        pushBeat(1, 32'h34, 1'b0, 1'b1, 0);
        expectWord(32'h34, 1'b1);
        waitDrain("tkeep", 200);

        // Output backpressure toggling every cycle during a 5-word packet.
        timeout_len = 16'd3;
        applyStimulus(0, 32'h51, 5, 0);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            o_tready = !o_tready;
            if (expQ.size() == 0 && pendingBeats() == 0) break;
        end
        o_tready = 1'b1;
        waitDrain("backpressure", 100);
        checkOutput("no abort under backpressure", 64'(abort_count), 64'd0);

        // Stall timeout on pathway 3: terminator, abort count, late beats flushed.
        timeout_len = 16'd8;
        expectHeader(3);
        pushBeat(3, 32'h41, 1'b1, 1'b0, 0);
        expectWord(32'h41, 1'b0);
        pushBeat(3, 32'h42, 1'b1, 1'b0, 0);
        expectWord(32'h42, 1'b0);
        expectWord(32'hDEAD_0003, 1'b1);
        pushBeat(3, 32'h43, 1'b1, 1'b0, 12);
        pushBeat(3, 32'h44, 1'b1, 1'b1, 0);
        waitDrain("timeout", 300);
        checkOutput("abort_count after timeout", 64'(abort_count), 64'd1);
        timeout_len = '0;

        // Reset in the middle of a packet.
        applyStimulus(1, 32'h81, 6, 2);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (expQ.size() <= 4) break;
        end
        checkOutput("mid-packet reached", 64'(expQ.size() <= 4), 64'd1);
        rst = 1'b1;
        for (int p = 0; p < NP; p++) beatQ[p].delete();
        expQ.delete();
        #1;
        checkOutput("mid reset o_tvalid", 64'(o_tvalid), 64'd0);
        checkOutput("mid reset i_tready", 64'(i_tready), 64'd0);
        checkOutput("mid reset abort_count", 64'(abort_count), 64'd0);
        checkOutput("mid reset active", 64'(o_active_pathway), 64'd0);
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        expSeq = 16'd0;

        // All pathways continuously valid: grant order 0,1,2,3,0,1,2,3 with seq 0..7.
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < NP; p++) begin
                applyStimulus(p, 32'h7000_0000 | 32'(p << 8) | 32'(k << 4), 2, 0);
            end
        end
        waitDrain("round robin", 400);

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL global timeout: got running, expected finished");
        $fatal(1, "[TB] global timeout");
    end

endmodule
